// File: rtl/proc_run_ctrl_if.sv
// proc_run_ctrl_if
//   Bundles the host-side controls and the core-side word buses of the run
//   controller. The controller connects through the slave modport and the host
//   or bench connects through the master modport.
//   Host to controller : start, inp_cfg, exp_words, exp_mask
//   Core to controller : core_out
//   Controller outputs : core_reset, core_inp, busy, done, pass, timeout,
//                        cycle_count, match_ch
//   Optional outputs   : chg_stamp, chg_seen (present only when
//                        PROC_RUN_CHG_STAMP_EN is defined)
interface proc_run_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int N_CH   = 2,
    parameter int CNT_W  = 16
);
    logic                     start;
    logic [N_CH*DATA_W-1:0]   inp_cfg;
    logic [N_CH*DATA_W-1:0]   exp_words;
    logic [N_CH-1:0]          exp_mask;
    logic [N_CH*DATA_W-1:0]   core_out;
    logic                     core_reset;
    logic [N_CH*DATA_W-1:0]   core_inp;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic                     timeout;
    logic [CNT_W-1:0]         cycle_count;
    logic [N_CH-1:0]          match_ch;
`ifdef PROC_RUN_CHG_STAMP_EN
    logic [N_CH*CNT_W-1:0]    chg_stamp;
    logic [N_CH-1:0]          chg_seen;
`endif

    modport slave (
        input  start, inp_cfg, exp_words, exp_mask, core_out,
        output core_reset, core_inp, busy, done, pass, timeout, cycle_count, match_ch
`ifdef PROC_RUN_CHG_STAMP_EN
        , output chg_stamp, chg_seen
`endif
    );

    modport master (
        output start, inp_cfg, exp_words, exp_mask, core_out,
        input  core_reset, core_inp, busy, done, pass, timeout, cycle_count, match_ch
`ifdef PROC_RUN_CHG_STAMP_EN
        , input chg_stamp, chg_seen
`endif
    );
endinterface

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
//   Run controller for the RISCV32I core. On start it latches the input words,
//   holds the core in reset for RESET_CYCLES cycles, then lets it run while
//   counting cycles and comparing the core output words against an expected
//   signature. It finishes with pass after STABLE_N consecutive matching cycles
//   or with timeout after MAX_CYCLES run cycles.
//   Ports: clock, reset (async, active-high), bus (proc_run_ctrl_if.slave).
//   Optional feature macro: PROC_RUN_CHG_STAMP_EN adds chg_stamp/chg_seen, which
//   record the run cycle at which each output word first changed.

// Per-channel compare; a masked-off channel always reports a match.
module proc_run_ctrl_lane #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] coreWord,
    input  logic [DATA_W-1:0] expWord,
    input  logic              maskBit,
    output logic              match
);
    assign match = (coreWord == expWord) | ~maskBit;
endmodule

module proc_run_ctrl #(
    parameter int DATA_W       = 32,
    parameter int N_CH         = 2,
    parameter int MAX_CYCLES   = 32,
    parameter int RESET_CYCLES = 2,
    parameter int STABLE_N     = 1,
    parameter int CNT_W        = 16
) (
    input logic           clock,
    input logic           reset,
    proc_run_ctrl_if.slave bus
);
    localparam int RST_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
    localparam int STB_W = $clog2(STABLE_N + 1);

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    state_t                        state;
    logic [RST_W-1:0]              rstCnt;
    logic [STB_W-1:0]              stable;
    logic [CNT_W-1:0]              cycleCnt;
    logic                          coreResetQ, busyQ, doneQ, passQ, timeoutQ;
    logic [N_CH*DATA_W-1:0]        coreInpQ;
    logic [N_CH-1:0][DATA_W-1:0]   coreWord, expWord;
    logic [N_CH-1:0]               matchCh;
    logic                          allMatch, startAcc;

    assign coreWord = bus.core_out;
    assign expWord  = bus.exp_words;

    for (genvar i = 0; i < N_CH; i++) begin : gLane
        proc_run_ctrl_lane #(.DATA_W(DATA_W)) uLane (
            .coreWord (coreWord[i]),
            .expWord  (expWord[i]),
            .maskBit  (bus.exp_mask[i]),
            .match    (matchCh[i])
        );
    end

    assign allMatch = &matchCh;
    assign startAcc = bus.start && (state == IDLE || state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rstCnt     <= '0;
            stable     <= '0;
            cycleCnt   <= '0;
            coreResetQ <= 1'b1;
            coreInpQ   <= '0;
            busyQ      <= 1'b0;
            doneQ      <= 1'b0;
            passQ      <= 1'b0;
            timeoutQ   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (startAcc) begin
                        state      <= RST;
                        coreInpQ   <= bus.inp_cfg;
                        coreResetQ <= 1'b1;
                        busyQ      <= 1'b1;
                        doneQ      <= 1'b0;
                        passQ      <= 1'b0;
                        timeoutQ   <= 1'b0;
                        cycleCnt   <= '0;
                        rstCnt     <= '0;
                    end
                end
                RST: begin
                    if (rstCnt == RST_W'(RESET_CYCLES - 1)) begin
                        state      <= RUN;
                        coreResetQ <= 1'b0;
                        cycleCnt   <= '0;
                        stable     <= '0;
                    end else begin
                        rstCnt <= rstCnt + 1'b1;
                    end
                end
                RUN: begin
                    // The count advances on the exit edge too, so on DONE it
                    // equals the number of RUN cycles spent.
                    cycleCnt <= cycleCnt + 1'b1;
                    stable   <= allMatch ? stable + 1'b1 : '0;
                    // Pass is checked first so it wins over a coincident timeout.
                    if (allMatch && stable == STB_W'(STABLE_N - 1)) begin
                        state      <= DONE;
                        passQ      <= 1'b1;
                        doneQ      <= 1'b1;
                        busyQ      <= 1'b0;
                        coreResetQ <= 1'b1;
                    end else if (cycleCnt == CNT_W'(MAX_CYCLES - 1)) begin
                        state      <= DONE;
                        timeoutQ   <= 1'b1;
                        doneQ      <= 1'b1;
                        busyQ      <= 1'b0;
                        coreResetQ <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.core_reset  = coreResetQ;
    assign bus.core_inp    = coreInpQ;
    assign bus.busy        = busyQ;
    assign bus.done        = doneQ;
    assign bus.pass        = passQ;
    assign bus.timeout     = timeoutQ;
    assign bus.cycle_count = cycleCnt;
    assign bus.match_ch    = matchCh;

`ifdef PROC_RUN_CHG_STAMP_EN
    // firstRun stays set through RST so the reference words are taken on the
    // first RUN cycle; later RUN cycles compare against that reference.
    logic                          firstRun;
    logic [N_CH-1:0][DATA_W-1:0]   refWord;
    logic [N_CH-1:0][CNT_W-1:0]    stampQ;
    logic [N_CH-1:0]               seenQ;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            firstRun <= 1'b0;
            refWord  <= '0;
            stampQ   <= '0;
            seenQ    <= '0;
        end else if (startAcc) begin
            firstRun <= 1'b1;
            stampQ   <= '0;
            seenQ    <= '0;
        end else if (state == RUN) begin
            firstRun <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                if (firstRun) begin
                    refWord[i] <= coreWord[i];
                end else if (!seenQ[i] && coreWord[i] != refWord[i]) begin
                    stampQ[i] <= cycleCnt;
                    seenQ[i]  <= 1'b1;
                end
            end
        end
    end

    assign bus.chg_stamp = stampQ;
    assign bus.chg_seen  = seenQ;
`endif
endmodule

// File: tb/tb_proc_run_ctrl.sv
module tb_proc_run_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;   // 0 -> dutA (STABLE_N=1), 1 -> dutB (STABLE_N=3)
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    proc_run_ctrl_if #(.DATA_W(32), .N_CH(2), .CNT_W(16)) ifA ();
    proc_run_ctrl_if #(.DATA_W(32), .N_CH(2), .CNT_W(16)) ifB ();

    proc_run_ctrl #(.DATA_W(32), .N_CH(2), .MAX_CYCLES(32), .RESET_CYCLES(2),
                    .STABLE_N(1), .CNT_W(16)) dutA (.clock(clk), .reset(rst), .bus(ifA));
    proc_run_ctrl #(.DATA_W(32), .N_CH(2), .MAX_CYCLES(32), .RESET_CYCLES(2),
                    .STABLE_N(3), .CNT_W(16)) dutB (.clock(clk), .reset(rst), .bus(ifB));

    logic        oCoreReset, oBusy, oDone, oPass, oTimeout;
    logic [63:0] oCoreInp;
    logic [15:0] oCnt;

    always_comb begin
        oCoreReset = sel ? ifB.core_reset  : ifA.core_reset;
        oBusy      = sel ? ifB.busy        : ifA.busy;
        oDone      = sel ? ifB.done        : ifA.done;
        oPass      = sel ? ifB.pass        : ifA.pass;
        oTimeout   = sel ? ifB.timeout     : ifA.timeout;
        oCoreInp   = sel ? ifB.core_inp    : ifA.core_inp;
        oCnt       = sel ? ifB.cycle_count : ifA.cycle_count;
    end

    typedef struct {
        logic [63:0] inp;
        logic [63:0] expw;
        logic [1:0]  mask;
        logic [63:0] pat;      // bit n set: core_out matches on RUN cycle n
        int          pulseAt;  // RUN cycle carrying a stray start (-1 none)
        bit          expPass;
        bit          expTo;
        int          expCnt;
        int          expLat;   // edges from start edge to done
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic setIns(input logic [63:0] inp, input logic [63:0] expw,
                          input logic [1:0] mask, input logic [63:0] co);
        ifA.inp_cfg = inp;  ifB.inp_cfg = inp;
        ifA.exp_words = expw; ifB.exp_words = expw;
        ifA.exp_mask = mask; ifB.exp_mask = mask;
        ifA.core_out = co;  ifB.core_out = co;
    endtask

    task automatic setStart(input logic s);
        if (sel) ifB.start = s; else ifA.start = s;
    endtask

    task automatic runVec(input vec_t v, input string nm);
        int k;
        int n;
        bit seen;
        setIns(v.inp, v.expw, v.mask, ~v.expw);
        @(posedge clk); #1; setStart(1'b1);
        @(posedge clk); #1; setStart(1'b0);
        @(negedge clk);
        chk({nm, ".rst0"}, 64'(oCoreReset), 64'd1);
        chk({nm, ".busy"}, 64'(oBusy), 64'd1);
        chk({nm, ".clr"}, {61'd0, oDone, oPass, oTimeout}, 64'd0);
        chk({nm, ".inp"}, oCoreInp, v.inp);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(posedge clk); k++; #1;
            n = k - 2;
            if (n >= 0 && n < 64 && v.pat[n]) setIns(v.inp, v.expw, v.mask, v.expw);
            else setIns(v.inp, v.expw, v.mask, ~v.expw);
            if (n == v.pulseAt) begin setStart(1'b1); setIns(~v.inp, v.expw, v.mask, sel ? ifB.core_out : ifA.core_out); end
            else setStart(1'b0);
            @(negedge clk);
            if (k == 1) chk({nm, ".rst1"}, 64'(oCoreReset), 64'd1);
            if (k == 2) chk({nm, ".run0"}, 64'(oCoreReset), 64'd0);
            if (oDone) seen = 1'b1;
        end
        setStart(1'b0);
        chk({nm, ".lat"}, seen ? 64'(k) : 64'hFFFF, 64'(v.expLat));
        chk({nm, ".pass"}, 64'(oPass), 64'(v.expPass));
        chk({nm, ".tout"}, 64'(oTimeout), 64'(v.expTo));
        chk({nm, ".cnt"}, 64'(oCnt), 64'(v.expCnt));
        chk({nm, ".inpHold"}, oCoreInp, v.inp);
        @(posedge clk); @(negedge clk);
        chk({nm, ".hold"}, {oDone, oCoreReset, oPass, oTimeout, 44'd0, oCnt},
            {1'b1, 1'b1, v.expPass, v.expTo, 44'd0, 16'(v.expCnt)});
    endtask

    vec_t        tbl[6];
    vec_t        v;
    logic [63:0] ones;
    logic [63:0] one;

    initial begin
        ones = '1;
        one  = 64'd1;
        //           inp                         expw                            mask   pat           pulse pass to cnt lat
        tbl[0] = '{{32'h7, 32'h5},              {32'h0, 32'hC},                 2'b01, ones << 9,    -1,   1, 0, 10, 12};
        tbl[1] = '{{32'h11, 32'h22},            {32'h1, 32'h2},                 2'b11, 64'd0,        -1,   0, 1, 32, 34};
        tbl[2] = '{{32'h3, 32'h4},              {32'hDEAD, 32'hBEEF},           2'b11, one << 31,    -1,   1, 0, 32, 34};
        tbl[3] = '{{32'hAA, 32'hBB},            {32'h5A, 32'h0},                2'b10, ones,         -1,   1, 0, 1,  3};
        tbl[4] = '{{32'h1, 32'h1},              {32'h12, 32'h34},               2'b11, one << 32,    -1,   0, 1, 32, 34};
        tbl[5] = '{{32'hF0F0, 32'h0F0F},        {32'hA5A5A5A5, 32'h5A5A5A5A},   2'b11, one << 5,     -1,   1, 0, 6,  8};

        ifA.start = 1'b0; ifB.start = 1'b0;
        setIns(64'h0, 64'h0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);

        // T1: reset then idle without start
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t1.coreReset", 64'(ifA.core_reset), 64'd1);
        chk("t1.coreInp", ifA.core_inp, 64'd0);
        chk("t1.flags", {60'd0, ifA.busy, ifA.done, ifA.pass, ifA.timeout}, 64'd0);
        chk("t1.cnt", 64'(ifA.cycle_count), 64'd0);
        chk("t1.matchCh", 64'(ifA.match_ch), 64'd0);

        sel = 1'b0;
        for (int i = 0; i < 6; i++) runVec(tbl[i], $sformatf("v%0d", i));

        // T5: STABLE_N=3, a mismatch restarts the streak; stray start in RUN
        sel = 1'b1;
        v = '{{32'h9, 32'h8}, {32'h13, 32'h37}, 2'b11, 64'h3B0, 2, 1, 0, 10, 12};
        runVec(v, "t5");

        // T6: reset in the middle of a run
        sel = 1'b0;
        setIns(64'h0000_0042_0000_0024, 64'h1, 2'b11, 64'h2);
        @(posedge clk); #1 setStart(1'b1);
        @(posedge clk); #1 setStart(1'b0);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6.coreReset", 64'(oCoreReset), 64'd1);
        chk("t6.coreInp", oCoreInp, 64'd0);
        chk("t6.flags", {60'd0, oBusy, oDone, oPass, oTimeout}, 64'd0);
        chk("t6.cnt", 64'(oCnt), 64'd0);
        @(negedge clk); rst = 1'b0;

        // second run times out, then a start from DONE must clear the flags
        v = '{{32'h6, 32'h7}, {32'h1, 32'h2}, 2'b11, 64'd0, -1, 0, 1, 32, 34};
        runVec(v, "t6b");
        v = '{{32'h8, 32'h9}, {32'h1, 32'h2}, 2'b00, 64'd0, -1, 1, 0, 1, 3};
        runVec(v, "t6c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
